alu_execute_unit: RTL and testbench

ALU_EXECUTE_UNIT -- requirements
Module: alu_execute_unit

---
 rtl/alu_exec_pkg.sv | 48 ++++
 rtl/alu_ctrl_decode.sv | 24 ++
 rtl/alu_execute_unit.sv | 119 +++++++++++
 tb/tb_alu_execute_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared constants for the execute stage: aluOp classes, funct codes and ALU operation codes.
// A helper decodes the R-type funct field into an ALU operation.
package alu_exec_pkg;

  localparam logic [3:0] ALUOP_ADD  = 4'b0000;
  localparam logic [3:0] ALUOP_SUB  = 4'b0001;
  localparam logic [3:0] ALUOP_FUNC = 4'b0010;
  localparam logic [3:0] ALUOP_AND  = 4'b0011;
  localparam logic [3:0] ALUOP_OR   = 4'b0100;
  localparam logic [3:0] ALUOP_SLT  = 4'b0101;
  localparam logic [3:0] ALUOP_XOR  = 4'b0110;

  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_XOR = 6'b100110;
  localparam logic [5:0] FUNC_NOR = 6'b100111;
  localparam logic [5:0] FUNC_SLT = 6'b101010;

  typedef enum logic [3:0] {
    CTRL_AND = 4'b0000,
    CTRL_OR  = 4'b0001,
    CTRL_ADD = 4'b0010,
    CTRL_XOR = 4'b0011,
    CTRL_SUB = 4'b0110,
    CTRL_SLT = 4'b0111,
    CTRL_NOR = 4'b1100
  } alu_ctrl_e;

  // Unknown funct values fall back to ADD so stray encodings still produce a defined result.
  function automatic alu_ctrl_e decodeFunc(input logic [5:0] f);
    alu_ctrl_e op;
    op = CTRL_ADD;
    case (f)
      FUNC_ADD: op = CTRL_ADD;
      FUNC_SUB: op = CTRL_SUB;
      FUNC_AND: op = CTRL_AND;
      FUNC_OR:  op = CTRL_OR;
      FUNC_XOR: op = CTRL_XOR;
      FUNC_NOR: op = CTRL_NOR;
      FUNC_SLT: op = CTRL_SLT;
      default:  op = CTRL_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of the main-control operation class and funct field into an ALU operation code.
module alu_ctrl_decode
  import alu_exec_pkg::*;
(
  input  logic [3:0] aluOp_i,
  input  logic [5:0] func_i,
  output logic [3:0] aluCtrl_o
);

  always_comb begin
    aluCtrl_o = CTRL_ADD;
    case (aluOp_i)
      ALUOP_ADD:  aluCtrl_o = CTRL_ADD;
      ALUOP_SUB:  aluCtrl_o = CTRL_SUB;
      ALUOP_FUNC: aluCtrl_o = decodeFunc(func_i);
      ALUOP_AND:  aluCtrl_o = CTRL_AND;
      ALUOP_OR:   aluCtrl_o = CTRL_OR;
      ALUOP_SLT:  aluCtrl_o = CTRL_SLT;
      ALUOP_XOR:  aluCtrl_o = CTRL_XOR;
      default:    aluCtrl_o = CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/alu_execute_unit.sv
// Execute stage: ALU, branch-target adder and the one-cycle output register bank with stall enable.
// Optional feature macro ALU_OVERFLOW_EN adds a registered signed-overflow flag for ADD/SUB.
module alu_execute_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             valid_in,
  input  logic [3:0]       aluOp,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] entr1,
  input  logic [WIDTH-1:0] entr2,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] branch_offset,
`ifdef ALU_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             valid_out,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] branch_pc
);

  logic [3:0]       aluCtrl_d;
  logic [WIDTH-1:0] sumRaw;
  logic [WIDTH-1:0] diffRaw;
  logic             sltBit;
  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic [WIDTH-1:0] branchPc_d;

  logic             valid_q;
  logic [3:0]       aluCtrl_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [WIDTH-1:0] branchPc_q;

  alu_ctrl_decode u_decode (
    .aluOp_i   (aluOp),
    .func_i    (func),
    .aluCtrl_o (aluCtrl_d)
  );

  assign sumRaw     = entr1 + entr2;
  assign diffRaw    = entr1 - entr2;
  assign sltBit     = $signed(entr1) < $signed(entr2);
  assign branchPc_d = pc + branch_offset;

  // Codes outside the defined operation set deliberately produce zero.
  always_comb begin
    result_d = '0;
    case (aluCtrl_d)
      CTRL_AND: result_d = entr1 & entr2;
      CTRL_OR:  result_d = entr1 | entr2;
      CTRL_ADD: result_d = sumRaw;
      CTRL_XOR: result_d = entr1 ^ entr2;
      CTRL_SUB: result_d = diffRaw;
      CTRL_SLT: result_d = {{(WIDTH-1){1'b0}}, sltBit};
      CTRL_NOR: result_d = ~(entr1 | entr2);
      default:  result_d = '0;
    endcase
  end

  assign zero_d = (result_d == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      aluCtrl_q  <= CTRL_ADD;
      result_q   <= '0;
      zero_q     <= 1'b1;
      branchPc_q <= '0;
    end else if (en) begin
      valid_q    <= valid_in;
      aluCtrl_q  <= aluCtrl_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      branchPc_q <= branchPc_d;
    end
  end

  assign valid_out  = valid_q;
  assign alu_ctrl   = aluCtrl_q;
  assign alu_result = result_q;
  assign zero       = zero_q;
  assign branch_pc  = branchPc_q;

`ifdef ALU_OVERFLOW_EN
  logic overflow_d;
  logic overflow_q;

  // Signed overflow: operands that agree in sign (ADD) or differ (SUB) yet flip the result sign.
  always_comb begin
    overflow_d = 1'b0;
    case (aluCtrl_d)
      CTRL_ADD: overflow_d = (entr1[WIDTH-1] == entr2[WIDTH-1]) &&
                             (sumRaw[WIDTH-1] != entr1[WIDTH-1]);
      CTRL_SUB: overflow_d = (entr1[WIDTH-1] != entr2[WIDTH-1]) &&
                             (diffRaw[WIDTH-1] != entr1[WIDTH-1]);
      default:  overflow_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (en) begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_alu_execute_unit.sv
// Scoreboard bench for alu_execute_unit: the driver queues hand-computed expectations,
// a monitor pops one per enabled clock edge and otherwise expects the outputs to hold.
module tb_alu_execute_unit;

  typedef struct {
    string       tag;
    logic        valid;
    logic [3:0]  ctrl;
    logic [31:0] result;
    logic        zero;
    logic [31:0] bpc;
    logic        ovf;
  } expT;

  logic        clk;
  logic        reset;
  logic        en;
  logic        valid_in;
  logic [3:0]  aluOp;
  logic [5:0]  func;
  logic [31:0] entr1;
  logic [31:0] entr2;
  logic [31:0] pc;
  logic [31:0] branch_offset;
  logic        valid_out;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] branch_pc;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  expT sbQ[$];
  expT lastExp;
  expT resetExp;
  int  assertCount = 0;
  int  failCount   = 0;

  alu_execute_unit #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .valid_in      (valid_in),
    .aluOp         (aluOp),
    .func          (func),
    .entr1         (entr1),
    .entr2         (entr2),
    .pc            (pc),
    .branch_offset (branch_offset),
`ifdef ALU_OVERFLOW_EN
    .overflow      (overflow),
`endif
    .valid_out     (valid_out),
    .alu_ctrl      (alu_ctrl),
    .alu_result    (alu_result),
    .zero          (zero),
    .branch_pc     (branch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compareAll(input expT e);
    checkOutput({e.tag, ".valid"},  32'(valid_out),  32'(e.valid));
    checkOutput({e.tag, ".ctrl"},   32'(alu_ctrl),   32'(e.ctrl));
    checkOutput({e.tag, ".result"}, alu_result,      e.result);
    checkOutput({e.tag, ".zero"},   32'(zero),       32'(e.zero));
    checkOutput({e.tag, ".bpc"},    branch_pc,       e.bpc);
`ifdef ALU_OVERFLOW_EN
    checkOutput({e.tag, ".ovf"},    32'(overflow),   32'(e.ovf));
`endif
  endtask

  // Drive one cycle of inputs at the falling edge; enabled cycles queue their expectation.
  task automatic applyStimulus(input string tag, input logic e, input logic v,
                               input logic [3:0] op, input logic [5:0] f,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] p, input logic [31:0] off,
                               input logic [3:0] xCtrl, input logic [31:0] xRes,
                               input logic xZero, input logic [31:0] xBpc, input logic xOvf);
    expT item;
    @(negedge clk);
    en = e; valid_in = v; aluOp = op; func = f;
    entr1 = a; entr2 = b; pc = p; branch_offset = off;
    if (e) begin
      item.tag = tag; item.valid = v; item.ctrl = xCtrl; item.result = xRes;
      item.zero = xZero; item.bpc = xBpc; item.ovf = xOvf;
      sbQ.push_back(item);
    end
  endtask

  // Monitor: on an enabled edge the next expectation becomes current, on a stalled edge it must hold.
  initial begin
    logic enAtEdge;
    logic rstAtEdge;
    forever begin
      @(posedge clk);
      enAtEdge  = en;
      rstAtEdge = reset;
      #1;
      if (!rstAtEdge && !reset) begin
        if (enAtEdge) begin
          if (sbQ.size() == 0) begin
            checkOutput("monitor.queue_empty", 32'(sbQ.size()), 32'd1);
          end else begin
            lastExp = sbQ.pop_front();
          end
        end
        compareAll(lastExp);
      end
    end
  end

  initial begin
    resetExp.tag = "reset"; resetExp.valid = 1'b0; resetExp.ctrl = 4'b0010;
    resetExp.result = 32'h0; resetExp.zero = 1'b1; resetExp.bpc = 32'h0; resetExp.ovf = 1'b0;
    lastExp = resetExp;
    reset = 1'b1; en = 1'b0; valid_in = 1'b0; aluOp = 4'h0; func = 6'h0;
    entr1 = 32'h0; entr2 = 32'h0; pc = 32'h0; branch_offset = 32'h0;

    #2;
    compareAll(resetExp);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus("add_func",  1, 1, 4'b0010, 6'h20, 32'd5,         32'd7,         32'h100,       32'h8,         4'b0010, 32'd12,        1'b0, 32'h108, 1'b0);
    applyStimulus("sub_eq",    1, 1, 4'b0001, 6'h00, 32'h0000_00AA, 32'h0000_00AA, 32'h10,        32'hFFFF_FFF0, 4'b0110, 32'h0,         1'b1, 32'h0,   1'b0);
    applyStimulus("slt_neg",   1, 1, 4'b0010, 6'h2A, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'h4,         4'b0111, 32'd1,         1'b0, 32'h4,   1'b0);
    applyStimulus("slt_swap",  1, 1, 4'b0010, 6'h2A, 32'd1,         32'hFFFF_FFFF, 32'h4,         32'h4,         4'b0111, 32'd0,         1'b1, 32'h8,   1'b0);
    applyStimulus("add_ovf",   1, 1, 4'b0000, 6'h00, 32'h7FFF_FFFF, 32'd1,         32'hFFFF_FFFC, 32'h8,         4'b0010, 32'h8000_0000, 1'b0, 32'h4,   1'b1);
    applyStimulus("and_op",    1, 1, 4'b0011, 6'h00, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0,         32'h0,         4'b0000, 32'h00F0_000F, 1'b0, 32'h0,   1'b0);
    applyStimulus("or_op",     1, 1, 4'b0100, 6'h00, 32'h0000_1200, 32'h0000_0034, 32'h0,         32'h0,         4'b0001, 32'h0000_1234, 1'b0, 32'h0,   1'b0);
    applyStimulus("xor_zero",  1, 1, 4'b0110, 6'h00, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0,         32'h0,         4'b0011, 32'h0,         1'b1, 32'h0,   1'b0);
    applyStimulus("nor_func",  1, 1, 4'b0010, 6'h27, 32'h0,         32'h0,         32'h0,         32'h0,         4'b1100, 32'hFFFF_FFFF, 1'b0, 32'h0,   1'b0);
    applyStimulus("bad_func",  1, 1, 4'b0010, 6'h3F, 32'd3,         32'd4,         32'h0,         32'h0,         4'b0010, 32'd7,         1'b0, 32'h0,   1'b0);
    applyStimulus("bad_aluop", 1, 1, 4'b1111, 6'h22, 32'd10,        32'd20,        32'h0,         32'h0,         4'b0010, 32'd30,        1'b0, 32'h0,   1'b0);
    applyStimulus("slt_op",    1, 1, 4'b0101, 6'h00, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0,         32'h0,         4'b0111, 32'd1,         1'b0, 32'h0,   1'b0);
    applyStimulus("sub_ovf",   1, 1, 4'b0010, 6'h22, 32'h8000_0000, 32'd1,         32'h0,         32'h0,         4'b0110, 32'h7FFF_FFFF, 1'b0, 32'h0,   1'b1);
    applyStimulus("no_valid",  1, 0, 4'b0000, 6'h00, 32'd1,         32'd1,         32'h0,         32'h0,         4'b0010, 32'd2,         1'b0, 32'h0,   1'b0);
    applyStimulus("and_func",  1, 1, 4'b0010, 6'h24, 32'hFF,        32'h0F,        32'h0,         32'h0,         4'b0000, 32'h0F,        1'b0, 32'h0,   1'b0);
    applyStimulus("xor_func",  1, 1, 4'b0010, 6'h26, 32'h5,         32'h3,         32'h0,         32'h0,         4'b0011, 32'h6,         1'b0, 32'h0,   1'b0);
    applyStimulus("or_func",   1, 1, 4'b0010, 6'h25, 32'h8,         32'h1,         32'h40,        32'h4,         4'b0001, 32'h9,         1'b0, 32'h44,  1'b0);

    // Stalled cycles with changing inputs: the monitor expects "or_func" to hold.
    applyStimulus("stall0", 0, 1, 4'b0001, 6'h00, 32'hFFFF_FFFF, 32'd1, 32'h123, 32'h1, 4'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus("stall1", 0, 0, 4'b0011, 6'h00, 32'h1234_5678, 32'h0, 32'h999, 32'h7, 4'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus("stall2", 0, 1, 4'b0010, 6'h2A, 32'h0,         32'h5, 32'h555, 32'h3, 4'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Reset between edges must clear the outputs immediately, with en low.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    sbQ.delete();
    lastExp = resetExp;
    compareAll(resetExp);

    // Enabled edge while reset is held must not load anything.
    @(negedge clk);
    en = 1'b1; valid_in = 1'b1; aluOp = 4'b0000; entr1 = 32'd100; entr2 = 32'd200;
    @(posedge clk);
    #1;
    compareAll(resetExp);
    @(negedge clk);
    reset = 1'b0;
    en = 1'b0;

    applyStimulus("post_rst_hold", 0, 1, 4'b0000, 6'h00, 32'd1, 32'd2, 32'h0, 32'h0, 4'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus("post_rst_sub",  1, 1, 4'b0010, 6'h22, 32'd9, 32'd4, 32'h20, 32'h40, 4'b0110, 32'd5, 1'b0, 32'h60, 1'b0);
    applyStimulus("tail_hold",     0, 0, 4'b0000, 6'h00, 32'd0, 32'd0, 32'h0, 32'h0, 4'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 10 && sbQ.size() != 0; i++) @(posedge clk);
    #2;
    checkOutput("drain", 32'(sbQ.size()), 32'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
